// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 scan-out of a 320x240 grayscale framebuffer with a 2-cycle pixel pipeline.
// Define VGA_PIXEL_DOUBLE_EN to scale the image 2x to full screen; otherwise it is centred 1:1.
module vga_frame_reader #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0]        hcnt_reg;
  logic [9:0]        vcnt_reg;
  logic              run_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic              win_d1_reg;
  logic              hs_d1_reg;
  logic              vs_d1_reg;
  logic              de_d1_reg;

  logic              h_last;
  logic              v_last;
  logic              visible;
  logic              hs_n;
  logic              vs_n;
  logic              window;
  logic              row_adv;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr_next;

  assign h_last  = (hcnt_reg == H_LAST);
  assign v_last  = (vcnt_reg == V_LAST);
  // run_reg is low only during the first cycle after reset, so nothing is shown or read from reset state.
  assign visible = run_reg && (hcnt_reg < H_VIS_C) && (vcnt_reg < V_VIS_C);
  assign hs_n    = !(run_reg && (hcnt_reg >= HS_FIRST) && (hcnt_reg <= HS_LAST));
  assign vs_n    = !(run_reg && (vcnt_reg >= VS_FIRST) && (vcnt_reg <= VS_LAST));

`ifdef VGA_PIXEL_DOUBLE_EN
  localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);

  assign window  = visible;
  assign col     = ADDR_W'(hcnt_reg >> 1);
  assign row_adv = visible && (hcnt_reg == H_VIS_LAST) && vcnt_reg[0];
`else
  localparam logic [9:0] X0     = 10'((H_VIS - IMG_W) / 2);
  localparam logic [9:0] X_END  = 10'((H_VIS - IMG_W) / 2 + IMG_W);
  localparam logic [9:0] X_LAST = 10'((H_VIS - IMG_W) / 2 + IMG_W - 1);
  localparam logic [9:0] Y0     = 10'((V_VIS - IMG_H) / 2);
  localparam logic [9:0] Y_END  = 10'((V_VIS - IMG_H) / 2 + IMG_H);

  assign window  = run_reg && (hcnt_reg >= X0) && (hcnt_reg < X_END) &&
                   (vcnt_reg >= Y0) && (vcnt_reg < Y_END);
  assign col     = ADDR_W'(hcnt_reg - X0);
  assign row_adv = window && (hcnt_reg == X_LAST);
`endif

  assign addr_next = row_base_reg + col;
  assign rd_en     = window && enable;
  assign rd_addr   = rd_en ? addr_next : addr_hold_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_reg      <= '0;
      vcnt_reg      <= '0;
      run_reg       <= 1'b0;
      row_base_reg  <= '0;
      addr_hold_reg <= '0;
      win_d1_reg    <= 1'b0;
      hs_d1_reg     <= 1'b1;
      vs_d1_reg     <= 1'b1;
      de_d1_reg     <= 1'b0;
      vga_r         <= '0;
      vga_g         <= '0;
      vga_b         <= '0;
      vga_hs        <= 1'b1;
      vga_vs        <= 1'b1;
      vga_de        <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (run_reg) begin
        if (h_last) begin
          hcnt_reg <= '0;
          vcnt_reg <= v_last ? 10'd0 : vcnt_reg + 10'd1;
        end else begin
          hcnt_reg <= hcnt_reg + 10'd1;
        end
      end
      // High while the counters sit at (0,0): the first cycle after reset, then every frame wrap.
      frame_start <= !run_reg || (h_last && v_last);

      if (vcnt_reg == 10'd0) begin
        row_base_reg <= '0;
      end else if (row_adv) begin
        row_base_reg <= row_base_reg + ADDR_W'(IMG_W);
      end
      if (rd_en) begin
        addr_hold_reg <= addr_next;
      end

      win_d1_reg <= rd_en;
      hs_d1_reg  <= hs_n;
      vs_d1_reg  <= vs_n;
      de_d1_reg  <= visible;

      vga_r  <= win_d1_reg ? rd_data : 8'd0;
      vga_g  <= win_d1_reg ? rd_data : 8'd0;
      vga_b  <= win_d1_reg ? rd_data : 8'd0;
      vga_hs <= hs_d1_reg;
      vga_vs <= vs_d1_reg;
      vga_de <= de_d1_reg;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: expectations are queued by cycle and checked by a monitor.
// Vertical timing is shortened (12-row image, 30-line frame); the horizontal line is full length.
module tb_vga_frame_reader;

  localparam int FRAME = 30 * 800;

  localparam int S_EN   = 0;
  localparam int S_ADDR = 1;
  localparam int S_RGB  = 2;
  localparam int S_HS   = 3;
  localparam int S_VS   = 4;
  localparam int S_DE   = 5;
  localparam int S_FS   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data = 8'd0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #20 clk = ~clk;

  vga_frame_reader #(
    .IMG_W(320), .IMG_H(12), .ADDR_W(17),
    .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .rd_addr(rd_addr),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_de(vga_de),
    .frame_start(frame_start)
  );

  // Synchronous-read framebuffer whose contents are addr[7:0].
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr[7:0];
  end

  // Cycle n = state after the n-th rising edge since reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int cy(int h, int v, int f);
    return 1 + f * FRAME + v * 800 + h;
  endfunction

  function automatic logic [31:0] sample(int sel);
    case (sel)
      S_EN:    return {31'd0, rd_en};
      S_ADDR:  return {15'd0, rd_addr};
      S_RGB:   return {8'd0, vga_r, vga_g, vga_b};
      S_HS:    return {31'd0, vga_hs};
      S_VS:    return {31'd0, vga_vs};
      S_DE:    return {31'd0, vga_de};
      default: return {31'd0, frame_start};
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string name);
    exp_t e;
    int i;
    e.cyc = c; e.sel = sel; e.exp = v; e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: at every falling edge, compare all entries due this cycle.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        act = sample(e.sel);
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s missed: due cyc=%0d seen at cyc=%0d", e.name, e.cyc, cyc);
        end else if (act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h", e.name, cyc, act, e.exp);
        end else begin
          $display("check %s cyc=%0d value=%0h ok", e.name, cyc, act);
        end
      end
    end
  end

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int e_off, e_on, cr, n;
    e_off = cy(300, 10, 1);
    e_on  = cy(310, 10, 1);
    cr    = cy(400, 15, 1);
    rst_n  = 1'b0;
    enable = 1'b1;

    // Timing after reset release
    expect_at(1, S_FS, 1, "fs_first");
    expect_at(1, S_HS, 1, "hs_reset");
    expect_at(1, S_RGB, 0, "rgb_reset");
    expect_at(2, S_FS, 0, "fs_one_cycle");
    expect_at(2, S_DE, 0, "de_before");
    expect_at(3, S_DE, 1, "de_rise");
    expect_at(642, S_DE, 1, "de_last_pixel");
    expect_at(643, S_DE, 0, "de_fall");
    expect_at(658, S_HS, 1, "hs_before");
    expect_at(659, S_HS, 0, "hs_start");
    expect_at(754, S_HS, 0, "hs_end");
    expect_at(755, S_HS, 1, "hs_after");
    expect_at(803, S_DE, 1, "de_line1");
    expect_at(cy(799, 25, 0) + 2, S_VS, 1, "vs_before");
    expect_at(cy(0, 26, 0) + 2, S_VS, 0, "vs_start");
    expect_at(cy(799, 27, 0) + 2, S_VS, 0, "vs_end");
    expect_at(cy(0, 28, 0) + 2, S_VS, 1, "vs_after");
    expect_at(FRAME, S_FS, 0, "fs_frame_end");
    expect_at(FRAME + 1, S_FS, 1, "fs_frame2");

`ifdef VGA_PIXEL_DOUBLE_EN
    expect_at(cy(0, 0, 0), S_EN, 1, "en_0_0");
    expect_at(cy(0, 0, 0), S_ADDR, 0, "addr_0_0");
    expect_at(cy(1, 1, 0), S_ADDR, 0, "addr_1_1");
    expect_at(cy(2, 0, 0), S_ADDR, 1, "addr_2_0");
    expect_at(cy(2, 0, 0) + 2, S_RGB, 32'h010101, "rgb_2_0");
    expect_at(cy(0, 2, 0), S_ADDR, 320, "addr_0_2");
    expect_at(cy(639, 23, 0), S_ADDR, 3839, "addr_last");
    expect_at(cy(640, 0, 0), S_EN, 0, "en_hblank");
    expect_at(e_off, S_ADDR, 1749, "addr_hold");
    expect_at(e_off + 1, S_RGB, 32'hd5d5d5, "rgb_before_off");
    expect_at(e_on, S_ADDR, 1755, "addr_reenable");
    expect_at(e_on + 2, S_RGB, 32'hdbdbdb, "rgb_reenable");
`else
    expect_at(cy(159, 6, 0), S_EN, 0, "en_border_left");
    expect_at(cy(160, 6, 0), S_EN, 1, "en_win_start");
    expect_at(cy(160, 6, 0), S_ADDR, 0, "addr_first");
    expect_at(cy(161, 7, 0), S_ADDR, 321, "addr_161_7");
    expect_at(cy(161, 7, 0) + 2, S_RGB, 32'h414141, "rgb_161_7");
    expect_at(cy(479, 17, 0), S_ADDR, 3839, "addr_last");
    expect_at(cy(479, 17, 0) + 2, S_RGB, 32'hffffff, "rgb_last");
    expect_at(cy(480, 17, 0), S_EN, 0, "en_border_right");
    expect_at(cy(100, 3, 0), S_EN, 0, "en_border_100_3");
    expect_at(cy(100, 3, 0) + 2, S_RGB, 0, "rgb_border_100_3");
    expect_at(e_off, S_ADDR, 1419, "addr_hold");
    expect_at(e_off + 1, S_RGB, 32'h8b8b8b, "rgb_before_off");
    expect_at(e_on, S_ADDR, 1430, "addr_reenable");
    expect_at(e_on + 2, S_RGB, 32'h969696, "rgb_reenable");
`endif

    // enable toggle mid-line
    expect_at(e_off - 1, S_EN, 1, "en_before_off");
    expect_at(e_off, S_EN, 0, "en_off");
    expect_at(e_off + 2, S_RGB, 0, "rgb_off");
    expect_at(e_off + 2, S_DE, 1, "de_during_off");
    expect_at(e_off + 2, S_HS, 1, "hs_during_off");
    expect_at(e_on + 1, S_RGB, 0, "rgb_last_off");
    expect_at(e_on, S_EN, 1, "en_on");

    // asynchronous reset mid-line
    expect_at(cr, S_RGB, 0, "rst_rgb");
    expect_at(cr, S_HS, 1, "rst_hs");
    expect_at(cr, S_VS, 1, "rst_vs");
    expect_at(cr, S_DE, 0, "rst_de");
    expect_at(cr, S_EN, 0, "rst_en");
    expect_at(cr, S_ADDR, 0, "rst_addr");
    expect_at(cr, S_FS, 0, "rst_fs");

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wait_cycle(e_off);
    enable = 1'b0;
    wait_cycle(e_on);
    enable = 1'b1;
    wait_cycle(cr);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    expect_at(1, S_FS, 1, "re_fs_first");
    expect_at(2, S_FS, 0, "re_fs_one_cycle");
    expect_at(3, S_DE, 1, "re_de_rise");
`ifdef VGA_PIXEL_DOUBLE_EN
    expect_at(cy(0, 0, 0), S_ADDR, 0, "re_addr_first");
    expect_at(cy(2, 0, 0), S_ADDR, 1, "re_addr_second");
    expect_at(cy(2, 0, 0) + 2, S_RGB, 32'h010101, "re_rgb_second");
`else
    expect_at(cy(160, 6, 0), S_ADDR, 0, "re_addr_first");
    expect_at(cy(161, 6, 0), S_ADDR, 1, "re_addr_second");
    expect_at(cy(161, 6, 0) + 2, S_RGB, 32'h010101, "re_rgb_second");
`endif
    @(negedge clk);
    rst_n = 1'b1;

    n = 0;
    while (sb.size() > 0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      errors += sb.size();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Scan-out stage directly downstream of the 2x nearest-neighbour upscaler. It reads the upscaler's 320x240 8-bit grayscale output framebuffer through a synchronous-read port and generates standard 640x480@60 Hz VGA timing from a 25 MHz pixel clock. Each grayscale byte is replicated onto R, G and B. It also emits a frame-start pulse so that control logic can schedule upscaler runs against the display frame.

## Interface
- `IMG_W`, 320: framebuffer width in pixels.
- `IMG_H`, 240: framebuffer height in pixels.
- `ADDR_W`, 17: framebuffer address width. Must cover `IMG_W*IMG_H` = 76800.
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in pixels.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.
- `clk`  in  1: pixel clock, 25 MHz. Single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: when low, the image is blanked to black and no reads are issued; timing keeps running.
- `rd_addr`  out  `ADDR_W`: framebuffer read address.
- `rd_en`  out  1: read strobe.
- `rd_data`  in  8: framebuffer data, valid exactly 1 cycle after the `rd_en`/`rd_addr` cycle.
- `vga_r`, `vga_g`, `vga_b`  out  8 each: pixel colour.
- `vga_hs`, `vga_vs`  out  1 each: sync outputs, active low.
- `vga_de`  out  1: high during the 640x480 visible area.
- `frame_start`  out  1: one-cycle pulse at the start of each frame.

## Operation
- Counters:
  - `hcnt` runs 0..799 and wraps to 0.
  - `vcnt` runs 0..524 and increments when `hcnt` wraps; it wraps 524->0.
  - Both are 10 bits.
- Stage 0 (counter cycle) decodes:
  - visible: `hcnt<640 && vcnt<480`.
  - hs: `hcnt` in [656,751] drives `vga_hs` low.
  - vs: `vcnt` in [490,491] drives `vga_vs` low.
  - window: see Configuration.
- Read issue: in stage 0, `rd_en` = window && `enable`. `rd_addr` is driven registered-free from stage-0 state.
  - When `rd_en` is low, `rd_addr` holds its last value.
- Address arithmetic:
  - `rd_addr = row_base + col`, with `col = hcnt - X0`.
  - `row_base` is a register that advances by `IMG_W` at the end of each windowed line.
  - `row_base` clears at `vcnt==0`.
  - No multiplier is used.
  - The maximum address is 76799; the address never wraps within a frame.
- Stage 1: `rd_data` returns. The window/enable flag and the hs, vs and de flags are carried through a 2-deep delay line.
- Stage 2 (output register):
  - `vga_r = vga_g = vga_b` = `rd_data` if the delayed window && enable flag is set, else 0.
  - `vga_hs`, `vga_vs` and `vga_de` take the delayed flags.
- `frame_start` is registered high for the one cycle after `hcnt==0 && vcnt==0` at stage 0. It is aligned with the first visible pixel's stage 0, so it leads `vga_de` by 2 cycles.
- `enable` is sampled at stage 0 per pixel. A mid-frame toggle takes effect on the next pixel, aligned through the pipeline; no tearing beyond that pixel.
- Reset (async assert, any time):
  - `hcnt`, `vcnt`, `row_base` and the pipeline are cleared.
  - Outputs go to: `vga_hs=1`, `vga_vs=1`, `vga_de=0`, RGB=0, `rd_en=0`, `rd_addr=0`, `frame_start=0`.
  - After deassertion the block starts a fresh frame at (0,0), and `frame_start` pulses on the first clock.

## Timing
- Period: 800 clocks per line and 420000 clocks per frame (~59.5 Hz at 25 MHz).
- Latency from the counter value to the VGA pins is exactly 2 cycles for RGB, sync and de alike; sync/data skew is 0.
- Read latency assumption: 1 cycle, synchronous BRAM. Stage 2 registers the BRAM output directly.
- `vga_hs` low pulse: 96 cycles. `vga_vs` low pulse: 2 lines (1600 cycles).

## Configuration
- `VGA_PIXEL_DOUBLE_EN` defined: the 320x240 image is doubled to fill the whole 640x480.
  - Window = visible.
  - `col = hcnt>>1`.
  - `row_base` advances by `IMG_W` only after odd visible lines, so each framebuffer row is shown twice.
- Not defined: the image is centred 1:1 with a black border.
  - X0=160, Y0=120.
  - Window is `hcnt` in [160,479] && `vcnt` in [120,359].
  - `row_base` advances after every windowed line.
  - Border pixels output 0 and issue no reads.

## Test plan
- Reset release with `enable=1`:
  - `frame_start` is high in cycle 1.
  - `vga_de` rises at cycle 3.
  - The first `vga_hs` low occurs 656 cycles after the first visible pixel and lasts 96 cycles.
  - Line period is 800 cycles; `vga_vs` low spans lines 490–491.
- Centred mode with BRAM model `data=addr[7:0]`:
  - At (`hcnt`=160, `vcnt`=120): `rd_addr=0`.
  - At (479,359): `rd_addr=76799`.
  - At (161,121): `rd_addr=321`, and `vga_r` shows 0x41 two cycles later.
  - Pixel (100,50): RGB=0 and `rd_en=0`.
- `VGA_PIXEL_DOUBLE_EN`:
  - (0,0) and (1,1) both read address 0.
  - (2,0) reads address 1.
  - (0,2) reads address 320.
  - (639,479) reads address 76799.
- `enable` deasserted at the pixel `hcnt`=300, `vcnt`=200:
  - RGB is 0 from 2 cycles later.
  - `rd_en` drops the same cycle.
  - Sync and de are unaffected.
  - Re-enabling restores the image at the next pixel with the correct address.
- Async reset asserted mid-line at (400,300):
  - Outputs go to reset values immediately, without waiting for a clock.
  - After release a full new frame begins: `frame_start` pulse, and the address sequence restarts at 0.
